// File: rtl/sti_pkg.sv
// Shared STI definitions: controller state encoding, word-length codes,
// the latched descriptor layout and a length-to-bit-count helper.
// Used by the request arbiter and intended for the serializer and later
// STI blocks.
package sti_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_FINISH = 3'd4
    } sti_state_e;

    typedef enum logic [1:0] {
        LEN_8  = 2'b00,
        LEN_16 = 2'b01,
        LEN_24 = 2'b10,
        LEN_32 = 2'b11
    } sti_len_e;

    // One parallel-word descriptor as presented to the serializer.
    typedef struct packed {
        logic [15:0] data;
        sti_len_e    length;
        logic        fill;
        logic        msb;
        logic        low;
        logic        eow;     // end-of-stream flag
    } sti_desc_t;

    localparam int BIT_CNT_W = 6;

    function automatic logic [BIT_CNT_W-1:0] len_bits(input sti_len_e len);
        case (len)
            LEN_8:   return 6'd8;
            LEN_16:  return 6'd16;
            LEN_24:  return 6'd24;
            default: return 6'd32;
        endcase
    endfunction

endpackage

// File: rtl/sti_req_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority selector.
// Ports:
//   req   in  N_REQ  request levels
//   ptr   in  PTR_W  index with highest priority this cycle
//   gnt   out N_REQ  one-hot winner (all zero when no request)
//   valid out 1      a winner exists
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic             valid
);

    int idx;

    // Scan from ptr upward with wrap; first set request wins.
    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sti_req_arbiter.sv
// sti_req_arbiter: shares one STI serializer between N_REQ requesters.
// Grants round-robin, latches the winner's descriptor onto pi_*, pulses
// load, then counts so_valid bits to detect completion, a late start
// (timeout) or a short burst.
// Ports:
//   clk, reset (async, active low)
//   req/req_data/req_length/req_fill/req_msb/req_low/req_end  requester side
//   gnt       one-hot one-cycle acceptance pulse
//   load      one-cycle strobe to serializer
//   pi_*      latched descriptor, stable until the next grant
//   so_valid  serializer bit-valid
//   busy      grant until word complete
//   err       sticky: start timeout or short burst
//   all_done  sticky: end-flagged word completed
module sti_req_arbiter
    import sti_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int START_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [16*N_REQ-1:0] req_data,
    input  logic [2*N_REQ-1:0]  req_length,
    input  logic [N_REQ-1:0]    req_fill,
    input  logic [N_REQ-1:0]    req_msb,
    input  logic [N_REQ-1:0]    req_low,
    input  logic [N_REQ-1:0]    req_end,
    output logic [N_REQ-1:0]    gnt,
    output logic                load,
    output logic [15:0]         pi_data,
    output logic [1:0]          pi_length,
    output logic                pi_fill,
    output logic                pi_msb,
    output logic                pi_low,
    output logic                pi_end,
    input  logic                so_valid,
    output logic                busy,
    output logic                err,
    output logic                all_done
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TMO_W = $clog2(START_TIMEOUT + 1);

    sti_state_e           state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    sti_desc_t            desc_q, desc_d;
    logic [N_REQ-1:0]     gnt_q, gnt_d;
    logic                 load_q, load_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;

    logic [N_REQ-1:0]     win_oh;
    logic                 win_vld;
    logic [PTR_W-1:0]     win_idx;
    sti_desc_t            win_desc;
    logic [BIT_CNT_W-1:0] bit_cnt_dec;
    logic [TMO_W-1:0]     tmo_inc;

    rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .gnt   (win_oh),
        .valid (win_vld)
    );

    // Encode winner index and mux its descriptor.
    always_comb begin
        win_idx  = '0;
        win_desc = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_oh[i]) begin
                win_idx  = PTR_W'(i);
                win_desc = {req_data[16*i +: 16], sti_len_e'(req_length[2*i +: 2]),
                            req_fill[i], req_msb[i], req_low[i], req_end[i]};
            end
        end
    end

    assign bit_cnt_dec = (bit_cnt_q == '0) ? '0 : bit_cnt_q - BIT_CNT_W'(1);
    assign tmo_inc     = tmo_cnt_q + TMO_W'(1);

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        desc_d    = desc_q;
        gnt_d     = '0;
        load_d    = 1'b0;
        busy_d    = busy_q;
        err_d     = err_q;
        done_d    = done_q;
        bit_cnt_d = bit_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    desc_d   = win_desc;
                    gnt_d    = win_oh;
                    busy_d   = 1'b1;
                    rr_ptr_d = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + PTR_W'(1);
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_d    = 1'b1;
                bit_cnt_d = len_bits(desc_q.length);
                tmo_cnt_d = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (so_valid) begin
                    // First bit is consumed on the transition to SHIFT.
                    bit_cnt_d = bit_cnt_dec;
                    state_d   = ST_SHIFT;
                end else begin
                    tmo_cnt_d = tmo_inc;
                    if (tmo_inc == TMO_W'(START_TIMEOUT)) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_SHIFT: begin
                if (so_valid) begin
                    bit_cnt_d = bit_cnt_dec;
                    if (bit_cnt_dec == '0) begin
                        busy_d = 1'b0;
                        if (desc_q.eow) begin
                            done_d  = 1'b1;
                            state_d = ST_FINISH;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    // bit_cnt is never zero while in SHIFT, so a gap is a short burst.
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_FINISH: begin
                busy_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            desc_q    <= '0;
            gnt_q     <= '0;
            load_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            bit_cnt_q <= '0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            desc_q    <= desc_d;
            gnt_q     <= gnt_d;
            load_q    <= load_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            done_q    <= done_d;
            bit_cnt_q <= bit_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign load      = load_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign all_done  = done_q;
    assign pi_data   = desc_q.data;
    assign pi_length = desc_q.length;
    assign pi_fill   = desc_q.fill;
    assign pi_msb    = desc_q.msb;
    assign pi_low    = desc_q.low;
    assign pi_end    = desc_q.eow;

endmodule

// File: tb/tb_sti_req_arbiter.sv
module tb_sti_req_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req = '0;
    logic [16*N-1:0] req_data = '0;
    logic [2*N-1:0] req_length = '0;
    logic [N-1:0]   req_fill = '0, req_msb = '0, req_low = '0, req_end = '0;
    logic           so_valid = 1'b0;
    logic [N-1:0]   gnt;
    logic           load, busy, err, all_done;
    logic [15:0]    pi_data;
    logic [1:0]     pi_length;
    logic           pi_fill, pi_msb, pi_low, pi_end;

    sti_req_arbiter #(.N_REQ(N), .START_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .req_length(req_length), .req_fill(req_fill), .req_msb(req_msb),
        .req_low(req_low), .req_end(req_end), .gnt(gnt), .load(load),
        .pi_data(pi_data), .pi_length(pi_length), .pi_fill(pi_fill),
        .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
        .so_valid(so_valid), .busy(busy), .err(err), .all_done(all_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [15:0] data;
        logic [1:0]  len;
        logic [3:0]  fl;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   mptr  = 0;
    logic prev_gnt = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arbitration: first requester at or after the pointer, wrapping.
    function automatic int rr_model(input logic [N-1:0] s, input int p);
        for (int k = 0; k < N; k++)
            if (s[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic int nbits_of(input int w);
        return 8 * (int'(req_length[2*w +: 2]) + 1);
    endfunction

    task automatic set_desc(input int i, input logic [15:0] d, input logic [1:0] l,
                            input logic [3:0] f);
        req_data[16*i +: 16] = d;
        req_length[2*i +: 2] = l;
        {req_fill[i], req_msb[i], req_low[i], req_end[i]} = f;
    endtask

    // Push the predicted grant, wait for it, then step to the load cycle.
    task automatic grant_word(input bit keep, output int w);
        exp_t e;
        int   t;
        w = rr_model(req, mptr);
        if (w < 0) w = 0;
        e.idx  = w;
        e.data = req_data[16*w +: 16];
        e.len  = req_length[2*w +: 2];
        e.fl   = {req_fill[w], req_msb[w], req_low[w], req_end[w]};
        sbq.push_back(e);
        mptr = (w + 1) % N;
        t = 0;
        do begin @(negedge clk); t++; end while (gnt == '0 && t < 30);
        if (gnt == '0) chk("gnt_wait", 32'(gnt), 32'(1) << w);
        if (!keep) req[w] = 1'b0;
        @(negedge clk);
        chk("busy_on", 32'(busy), 1);
    endtask

    task automatic shift_bits(input int n);
        repeat (n) begin so_valid = 1'b1; @(negedge clk); end
        so_valid = 1'b0;
    endtask

    task automatic serve(input bit keep, input int gap);
        int w;
        grant_word(keep, w);
        repeat (gap) @(negedge clk);
        shift_bits(nbits_of(w));
        chk("busy_off", 32'(busy), 0);
        chk("pi_stable", 32'(pi_data), 32'(req_data[16*w +: 16]));
    endtask

    task automatic check_reset_outputs();
        chk("rst_ctl", 32'({gnt, load, busy, err, all_done, pi_length,
                            pi_fill, pi_msb, pi_low, pi_end}), 0);
        chk("rst_pi_data", 32'(pi_data), 0);
    endtask

    task automatic do_reset();
        so_valid = 1'b0;
        req      = '0;
        reset    = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mptr  = 0;
    endtask

    // Monitor: every gnt pulse is matched against the scoreboard head,
    // and load must follow a grant by exactly one cycle.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (gnt != '0) begin
                if (sbq.size() == 0) chk("unexpected_gnt", 32'(gnt), 0);
                else begin
                    e = sbq.pop_front();
                    chk("gnt", 32'(gnt), 32'(1) << e.idx);
                    chk("pi_data", 32'(pi_data), 32'(e.data));
                    chk("pi_length", 32'(pi_length), 32'(e.len));
                    chk("pi_flags", 32'({pi_fill, pi_msb, pi_low, pi_end}), 32'(e.fl));
                end
            end
            if (prev_gnt || load) chk("load", 32'(load), 32'(prev_gnt));
            prev_gnt = (gnt != '0);
        end else begin
            prev_gnt = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int w;
        int g;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_gnt", 32'(gnt), 0);

        // Single 8-bit word from requester 0.
        set_desc(0, 16'hA5C3, 2'b00, 4'b0000);
        req[0] = 1'b1;
        serve(1'b0, 0);

        // All four held, 16-bit words: grants follow 0,1,2,3,0.
        for (int i = 0; i < N; i++) set_desc(i, 16'h1000 + 16'(i), 2'b01, 4'b1010);
        req = '1;
        for (int k = 0; k < 5; k++) serve(1'b1, k % 3);
        req = '0;

        // Randomised request sets and descriptors.
        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < N; i++)
                set_desc(i, 16'($urandom), 2'($urandom_range(0, 3)),
                         {3'($urandom), 1'b0});
            req = N'($urandom_range(1, (1 << N) - 1));
            while (req != '0) serve(1'b0, $urandom_range(0, 6));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Start timeout: no so_valid after load.
        set_desc(3, 16'hBEEF, 2'b00, 4'b0000);
        req[3] = 1'b1;
        grant_word(1'b0, w);
        repeat (14) @(negedge clk);
        chk("tmo_not_yet", 32'(err), 0);
        @(negedge clk);
        chk("tmo_err", 32'(err), 1);
        chk("tmo_busy", 32'(busy), 0);
        set_desc(0, 16'h0F0F, 2'b00, 4'b0000);
        req[0] = 1'b1;
        serve(1'b0, 1);
        chk("tmo_err_sticky", 32'(err), 1);
        do_reset();
        chk("err_cleared", 32'(err), 0);

        // Short burst: 32-bit word cut off after 20 bits.
        set_desc(1, 16'h1234, 2'b11, 4'b0100);
        req[1] = 1'b1;
        grant_word(1'b0, w);
        shift_bits(20);
        chk("short_not_yet", 32'(err), 0);
        chk("short_busy_hold", 32'(busy), 1);
        @(negedge clk);
        chk("short_err", 32'(err), 1);
        chk("short_busy", 32'(busy), 0);
        set_desc(2, 16'h5555, 2'b00, 4'b0000);
        req[2] = 1'b1;
        serve(1'b0, 0);
        do_reset();

        // End flag: 24-bit word completes into FINISH.
        set_desc(1, 16'hCAFE, 2'b10, 4'b0001);
        req[1] = 1'b1;
        grant_word(1'b0, w);
        shift_bits(24);
        chk("end_done", 32'(all_done), 1);
        chk("end_busy", 32'(busy), 0);
        req = '1;
        g = 0;
        repeat (10) begin @(negedge clk); if (gnt != '0 || load) g++; end
        chk("finish_nognt", g, 0);
        chk("finish_done_sticky", 32'(all_done), 1);
        do_reset();
        chk("done_cleared", 32'(all_done), 0);

        // Reset in the middle of SHIFT.
        set_desc(1, 16'h7777, 2'b01, 4'b0000);
        req[1] = 1'b1;
        grant_word(1'b0, w);
        shift_bits(5);
        do_reset();
        repeat (3) @(negedge clk);
        chk("post_rst_idle", 32'({gnt, load, busy}), 0);
        // Pointer back at 0: 0 wins over 2, then 2 alone.
        set_desc(0, 16'h0A0A, 2'b00, 4'b1000);
        set_desc(2, 16'h2B2B, 2'b01, 4'b0010);
        req = 4'b0101;
        serve(1'b0, 0);
        serve(1'b0, 2);
        set_desc(2, 16'h2C2C, 2'b00, 4'b0000);
        req[2] = 1'b1;
        serve(1'b0, 0);

        repeat (3) @(negedge clk);
        chk("sb_drain", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sti_req_arbiter.md
# sti_req_arbiter

Round-robin scheduler that shares the single STI serializer between `N_REQ` parallel-word requesters. It latches one requester's descriptor, issues a one-cycle `load` to the serializer and holds the descriptor stable. It counts the serializer's `so_valid` bits to detect completion, then grants the next requester. It sits between the requesting producers and the `pi_*`/`load` inputs of the serializer, and it raises `all_done` once a word flagged `end` has fully shifted out.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `START_TIMEOUT`, 15, max cycles from `load` to first `so_valid` before error

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req`  in  N_REQ  per-requester request level; held until granted
- `req_data`  in  16*N_REQ  descriptor data, requester i at [16i+15:16i]
- `req_length`  in  2*N_REQ  00=8b, 01=16b, 10=24b, 11=32b
- `req_fill`, `req_msb`, `req_low`, `req_end`  in  N_REQ each  descriptor flags
- `gnt`  out  N_REQ  one-hot, one-cycle acceptance pulse
- `load`  out  1  one-cycle load strobe to serializer
- `pi_data`  out  16  latched descriptor data
- `pi_length`  out  2  latched descriptor length
- `pi_fill`, `pi_msb`, `pi_low`, `pi_end`  out  1 each  latched descriptor flags
- `so_valid`  in  1  serializer output-valid, one cycle per bit
- `busy`  out  1  high from grant until word complete
- `err`  out  1  sticky: start timeout or short burst
- `all_done`  out  1  sticky: end-flagged word completed

## Operation
- States: IDLE, LOAD, WAIT, SHIFT, FINISH.
- IDLE:
  - If `req`≠0, select the winner by round-robin starting at `rr_ptr`.
  - Latch its descriptor into the `pi_*` registers, pulse `gnt[winner]`, set `busy`, and go to LOAD.
  - Set `rr_ptr` to (winner+1) mod N_REQ.
- LOAD: assert `load` for exactly one cycle. Load `bit_cnt` = 8*(length+1) and `tmo_cnt` = 0, then go to WAIT.
- WAIT:
  - `so_valid`=1: decrement `bit_cnt` and go to SHIFT. The first bit is counted here.
  - Otherwise increment `tmo_cnt`. When it reaches START_TIMEOUT, set `err` and return to IDLE with `busy`=0.
- SHIFT:
  - Each `so_valid`=1 cycle decrements `bit_cnt`.
  - If `bit_cnt` reaches 0: go to FINISH when latched `pi_end`=1, otherwise go to IDLE. `busy` falls on that transition.
  - If `so_valid`=0 while `bit_cnt`≠0, the burst is short: set `err` and go to IDLE.
- FINISH: terminal. Set `all_done`. `busy`, `load` and `gnt` are 0. `req` is ignored until reset.
- `pi_*` change only on grant and stay stable through WAIT, SHIFT and FINISH.
- `bit_cnt` is 6 bits wide (max 32). Decrement saturates at 0.
- `err` and `all_done` clear only on reset.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, and every output 0, including `pi_data` = 16'h0000.
- Reset assertion mid-transfer aborts immediately to these values. No `gnt` or `load` pulse follows reset release until the next `req`.
- Cycle T: `req` seen in IDLE. T+1: `gnt` and `pi_*` valid, state LOAD. T+2: `load`=1. T+3 onward: WAIT.
- Minimum gap between back-to-back words is 2 idle cycles after the last `so_valid`:
  - the return to IDLE;
  - the grant in IDLE.
- Simultaneous requests are served strictly in round-robin order. A requester that drops `req` before its grant is skipped without penalty.
- `req` asserted in the same cycle the state returns to IDLE is arbitrated on the next cycle.

## Structure
- Shared package `sti_pkg`:
  - state encoding;
  - length codes;
  - function `len_bits(length)` returning 8/16/24/32.
  The serializer and future STI blocks reuse it.
- One natural sub-module: `rr_pick`, a combinational round-robin priority selector taking `req` and `rr_ptr` and producing a one-hot winner plus a valid flag.

## Test plan
- Single 8-bit word: `req`[0], length 00, data 16'hA5C3.
  - `gnt`=0001 at T+1 and `load` at T+2.
  - 8 `so_valid` cycles, then `busy` falls and state returns to IDLE.
- Round-robin fairness: `req`=1111 held, each word 16-bit.
  - Grants go 0,1,2,3,0.
  - After one grant to 2, the next grant is 3, not 0.
- Timeout: grant a word and never raise `so_valid`. `err`=1 after START_TIMEOUT (15) cycles in WAIT, and the next request is still served.
- Short burst: length 11 (32 bits), `so_valid` dropped after 20 bits. `err`=1 and state returns to IDLE.
- End flag: a 24-bit word with `req_end`=1.
  - After 24 bits, `all_done`=1.
  - Further `req` produce no `gnt` until reset.
- Reset mid-SHIFT: `reset`=0 after 5 bits.
  - All outputs are 0 at once.
  - After release, a new `req`[2] is granted with `rr_ptr` back at 0.
